mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single-ported unified memory shared by the IF stage (instruction fetch) and the MEM stage (data load/store). It grants one requester at a time, drives the memory through a fixed-latency read / single-cycle write sequence, and returns data with a valid pulse. It also generates per-stage stall signals, so the pipeline holds IF or MEM until its access completes.

## Interface
Parameters:
- LAT, 2: memory read latency in cycles from the cycle ram_en is high to the cycle ram_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hlt  in  1  processor halted; no new grants while high.
- if_req  in  1  IF fetch request, level, held until if_valid.
- if_addr  in  16  fetch address.
- if_rdata  out  16  fetched instruction, meaningful only when if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- mem_re  in  1  MEM load request, level.
- mem_we  in  1  MEM store request, level.
- mem_addr  in  16  data address.
- mem_wdata  in  16  store data.
- mem_rdata  out  16  load data, meaningful only when mem_valid.
- mem_valid  out  1  one-cycle load/store completion pulse.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM and older stages must hold.
- ram_en  out  1  memory access strobe, registered.
- ram_we  out  1  memory write enable, registered.
- ram_addr  out  16  memory address, registered.
- ram_wdata  out  16  memory write data, registered.
- ram_rdata  in  16  memory read data.

## Operation
- States: IDLE, RD_WAIT, WR.
- IDLE:
  - Arbitration is sampled each cycle when hlt=0.
  - MEM has fixed priority over IF, because it is the older instruction.
  - mem_we=1 → WR. mem_re=1 → RD_WAIT with owner=MEM. Otherwise if_req=1 → RD_WAIT with owner=IF.
  - mem_re and mem_we both high is treated as a store.
- On a grant, ram_addr, ram_wdata and the owner are latched. Requester address/data changes after the grant are ignored.
- The cycle after a grant:
  - ram_en=1 for exactly one cycle.
  - ram_we=1 for exactly one cycle if the grant was a store.
- WR: mem_valid=1 in the same cycle ram_en/ram_we are high. The next state is IDLE.
- RD_WAIT:
  - A 4-bit counter is loaded with LAT when ram_en is asserted and decrements each cycle.
  - In the cycle the counter reaches 0, the owner's valid is 1 and its rdata = ram_rdata (combinational pass-through). The next state is IDLE.
- Non-owner rdata outputs are held at 0.
- stall_if = if_req & ~if_valid.
- stall_mem = (mem_re | mem_we) & ~mem_valid.
- Stalls are combinational and cover both waiting-for-grant and in-flight cycles.
- Requesters update their request on the cycle after their valid pulse. The new request is arbitrated from IDLE on that cycle.
- hlt:
  - Blocks new grants only. An in-flight access completes normally and its valid still pulses.
  - Stalls stay asserted for pending requests.
- Reset:
  - Reset is asynchronous. On assertion, state=IDLE; ram_en, ram_we, ram_addr, ram_wdata, counter and owner = 0; if_valid and mem_valid = 0.
  - In-flight accesses are discarded with no valid pulse. Requests still held after reset release are re-arbitrated from scratch.
- IF cannot starve indefinitely: MEM is bounded to one request per instruction, and IF is granted whenever MEM is idle.

## Timing
- Read, request first seen in IDLE at cycle T:
  - Grant at T.
  - ram_en at T+1.
  - valid at T+1+LAT.
  - Next grant earliest at T+2+LAT.
- Store, request at T: ram_en/ram_we at T+1, mem_valid at T+1, next grant at T+2.
- A request arriving while another access is in flight waits. It is granted in the first IDLE cycle in which it is the highest-priority request and hlt=0.
- Output reset values:
  - All registered outputs are 0.
  - if_rdata and mem_rdata are 0.
  - stall_if and stall_mem follow their equations, so they are 0 if no request is held.

## Test plan
All scenarios use LAT=2.
- IF fetch: if_req=1 with if_addr=0x0010 from cycle 0, memory returns 0xBEEF.
  - ram_en=1 with ram_addr=0x0010 at cycle 1.
  - if_valid=1 with if_rdata=0xBEEF at cycle 3.
  - stall_if=1 in cycles 0–2 and 0 in cycle 3.
- Contention: mem_re (addr 0x0040) and if_req (addr 0x0011) both high at cycle 0.
  - MEM: ram_en at cycle 1 with ram_addr=0x0040, mem_valid at cycle 3.
  - IF: granted at cycle 4, ram_en at cycle 5 with ram_addr=0x0011, if_valid at cycle 7.
  - stall_if=1 in cycles 0–6.
- Store: mem_we=1 with addr 0x0020 and data 0x1234 at cycle 0, if_req also high.
  - ram_en=ram_we=1, ram_addr=0x0020, ram_wdata=0x1234 and mem_valid=1, all at cycle 1.
  - IF ram_en at cycle 3.
- Both mem_re and mem_we high: a store is performed, ram_we=1.
- hlt: hlt=1 at cycle 2 of an in-flight IF read.
  - if_valid still pulses at cycle 3.
  - A held mem_re gets no ram_en while hlt=1.
  - Clearing hlt at cycle 10 gives ram_en at cycle 11.
- Reset mid-read: rst_n=0 at cycle 2 of an IF read.
  - All outputs are 0 immediately and there is no if_valid at cycle 3.
  - After release with if_req held, the first release cycle re-grants and ram_en follows one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the single-ported unified memory between the
// IF stage (instruction fetch) and the MEM stage (load/store). MEM has fixed
// priority because it carries the older instruction. Each grant launches a
// one-cycle registered memory strobe. For a read, a countdown then waits out
// the fixed read latency and passes the read data straight through to the
// owner. The per-stage stall outputs hold a requester until its valid pulse.
module mem_port_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hlt,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2
    } state_t;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_MEM = 1'b1;
    localparam logic [3:0] LAT_C   = 4'(LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;

    logic        rd_done_s;

    // Next-state logic: grant in IDLE (store > load > fetch), count down the
    // read latency in RD_WAIT, and spend one cycle in WR for a store.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (hlt) begin
                    state_d = ST_IDLE;
                end else if (mem_we) begin
                    // A simultaneous load and store request is treated as a store.
                    state_d     = ST_WR;
                    owner_d     = OWN_MEM;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                end else if (mem_re) begin
                    state_d     = ST_RD_WAIT;
                    owner_d     = OWN_MEM;
                    cnt_d       = LAT_C;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                end else if (if_req) begin
                    state_d     = ST_RD_WAIT;
                    owner_d     = OWN_IF;
                    cnt_d       = LAT_C;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = mem_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // The counter holds LAT in the ram_en cycle, so it reaches
                // zero exactly LAT cycles after the strobe.
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and memory-interface registers, cleared asynchronously so that an
    // in-flight access is dropped without a valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= OWN_IF;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 16'h0000;
            ram_wdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign rd_done_s = (state_q == ST_RD_WAIT) && (cnt_q == 4'd0);

    // Completion pulses are decoded from registered state. Read data is
    // passed through only to the owner in its valid cycle and is zero otherwise.
    assign if_valid  = rd_done_s && (owner_q == OWN_IF);
    assign mem_valid = (rd_done_s && (owner_q == OWN_MEM)) || (state_q == ST_WR);
    assign if_rdata  = if_valid ? ram_rdata : 16'h0000;
    assign mem_rdata = (rd_done_s && (owner_q == OWN_MEM)) ? ram_rdata : 16'h0000;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = (mem_re | mem_we) & ~mem_valid;

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (LAT=2). Inputs change 1 time unit
// after the rising edge that opens cycle c, and outputs are sampled on the
// following falling edge of the same cycle.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hlt;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int checks_r;
    int failures_r;

    mem_port_arbiter #(.LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hlt       (hlt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hlt       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 16'h0000;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        ram_rdata = 16'h0000;
    endtask

    task automatic settle();
        clear_inputs();
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    // Directed scenarios.
    initial begin
        checks_r   = 0;
        failures_r = 0;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_ram_en",    {31'd0, ram_en},    32'd0);
        check_val("rst_ram_we",    {31'd0, ram_we},    32'd0);
        check_val("rst_ram_addr",  {16'd0, ram_addr},  32'd0);
        check_val("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        check_val("rst_if_valid",  {31'd0, if_valid},  32'd0);
        check_val("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_val("rst_if_rdata",  {16'd0, if_rdata},  32'd0);
        check_val("rst_mem_rdata", {16'd0, mem_rdata}, 32'd0);
        check_val("rst_stall_if",  {31'd0, stall_if},  32'd0);
        check_val("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // IF fetch: grant at 0, ram_en at 1, if_valid at 3.
        for (int c = 0; c < 4; c++) begin
            if_req    = 1'b1;
            if_addr   = 16'h0010;
            ram_rdata = 16'hBEEF;
            @(negedge clk);
            check_val("if_ram_en",   {31'd0, ram_en},   {31'd0, c == 1});
            check_val("if_valid",    {31'd0, if_valid}, {31'd0, c == 3});
            check_val("if_stall",    {31'd0, stall_if}, {31'd0, c < 3});
            if (c == 1) check_val("if_ram_addr", {16'd0, ram_addr}, 32'h0010);
            if (c == 3) check_val("if_rdata",    {16'd0, if_rdata}, 32'hBEEF);
            if (c == 3) check_val("if_mem_rdata_zero", {16'd0, mem_rdata}, 32'h0);
            next_cycle();
        end
        settle();

        // Contention: MEM load first, IF granted at 4.
        for (int c = 0; c < 8; c++) begin
            mem_re    = (c < 4);
            mem_addr  = 16'h0040;
            if_req    = 1'b1;
            if_addr   = 16'h0011;
            ram_rdata = (c == 3) ? 16'h1357 : ((c == 7) ? 16'h2468 : 16'h0000);
            @(negedge clk);
            check_val("ct_ram_en",    {31'd0, ram_en},    {31'd0, (c == 1) || (c == 5)});
            check_val("ct_mem_valid", {31'd0, mem_valid}, {31'd0, c == 3});
            check_val("ct_if_valid",  {31'd0, if_valid},  {31'd0, c == 7});
            check_val("ct_stall_if",  {31'd0, stall_if},  {31'd0, c <= 6});
            check_val("ct_stall_mem", {31'd0, stall_mem}, {31'd0, c <= 2});
            if (c == 1) check_val("ct_mem_addr", {16'd0, ram_addr}, 32'h0040);
            if (c == 5) check_val("ct_if_addr",  {16'd0, ram_addr}, 32'h0011);
            if (c == 3) check_val("ct_mem_rdata", {16'd0, mem_rdata}, 32'h1357);
            if (c == 3) check_val("ct_if_rdata_zero", {16'd0, if_rdata}, 32'h0);
            if (c == 7) check_val("ct_if_rdata", {16'd0, if_rdata}, 32'h2468);
            if (c == 7) check_val("ct_mem_rdata_zero", {16'd0, mem_rdata}, 32'h0);
            next_cycle();
        end
        settle();

        // Store with IF pending; requester address/data change after the grant.
        for (int c = 0; c < 6; c++) begin
            mem_we    = (c < 2);
            mem_addr  = (c == 0) ? 16'h0020 : 16'hFFFF;
            mem_wdata = (c == 0) ? 16'h1234 : 16'hFFFF;
            if_req    = 1'b1;
            if_addr   = 16'h0030;
            ram_rdata = 16'h0BAD;
            @(negedge clk);
            check_val("st_ram_en",    {31'd0, ram_en},    {31'd0, (c == 1) || (c == 3)});
            check_val("st_ram_we",    {31'd0, ram_we},    {31'd0, c == 1});
            check_val("st_mem_valid", {31'd0, mem_valid}, {31'd0, c == 1});
            check_val("st_if_valid",  {31'd0, if_valid},  {31'd0, c == 5});
            if (c == 1) check_val("st_addr",  {16'd0, ram_addr},  32'h0020);
            if (c == 1) check_val("st_wdata", {16'd0, ram_wdata}, 32'h1234);
            if (c == 3) check_val("st_if_addr", {16'd0, ram_addr}, 32'h0030);
            next_cycle();
        end
        settle();

        // Load and store together behave as a store.
        for (int c = 0; c < 3; c++) begin
            mem_re    = (c < 2);
            mem_we    = (c < 2);
            mem_addr  = 16'h0050;
            mem_wdata = 16'h9ABC;
            @(negedge clk);
            check_val("rw_ram_we",    {31'd0, ram_we},    {31'd0, c == 1});
            check_val("rw_mem_valid", {31'd0, mem_valid}, {31'd0, c == 1});
            if (c == 1) check_val("rw_wdata", {16'd0, ram_wdata}, 32'h9ABC);
            next_cycle();
        end
        settle();

        // hlt during an IF read: the read completes, the held load waits until hlt drops.
        for (int c = 0; c < 15; c++) begin
            if_req    = (c < 4);
            if_addr   = 16'h0060;
            hlt       = (c >= 2) && (c < 10);
            mem_re    = (c >= 2) && (c < 14);
            mem_addr  = 16'h0070;
            ram_rdata = 16'h4321;
            @(negedge clk);
            check_val("hl_ram_en",    {31'd0, ram_en},    {31'd0, (c == 1) || (c == 11)});
            check_val("hl_if_valid",  {31'd0, if_valid},  {31'd0, c == 3});
            check_val("hl_mem_valid", {31'd0, mem_valid}, {31'd0, c == 13});
            check_val("hl_stall_mem", {31'd0, stall_mem}, {31'd0, (c >= 2) && (c <= 12)});
            if (c == 11) check_val("hl_addr", {16'd0, ram_addr}, 32'h0070);
            next_cycle();
        end
        settle();

        // Reset in the middle of an IF read; re-grant on the first release cycle.
        for (int c = 0; c < 8; c++) begin
            if_req    = 1'b1;
            if_addr   = 16'h0080;
            ram_rdata = 16'hCAFE;
            rst_n     = !((c == 2) || (c == 3));
            @(negedge clk);
            check_val("rs_ram_en",   {31'd0, ram_en},   {31'd0, (c == 1) || (c == 5)});
            check_val("rs_if_valid", {31'd0, if_valid}, {31'd0, c == 7});
            if (c == 2) check_val("rs_ram_addr_clr", {16'd0, ram_addr}, 32'h0);
            if (c == 3) check_val("rs_if_rdata_zero", {16'd0, if_rdata}, 32'h0);
            if (c == 5) check_val("rs_ram_addr", {16'd0, ram_addr}, 32'h0080);
            if (c == 7) check_val("rs_if_rdata", {16'd0, if_rdata}, 32'hCAFE);
            next_cycle();
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
